oracle_event_queue: RTL and testbench

- Multi-lane event collector for the core oracle.
- Captures per-cycle pipeline events (decode, issue, writeback, commit) from up to NB_LANES lanes into a DEPTH-entry in-order FIFO.
- Applies squash filtering by age, then drains one event per cycle through a valid/ready port.
- Successor to the single-event-per-call oracle hooks: adds multi-lane capture, buffering, backpressure, squash filtering and overflow accounting.

---
 rtl/oracle_event_queue.sv | 170 +++++++++++++++++
 tb/tb_oracle_event_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oracle_event_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | oracle_event_queue                                                         |
// | Multi-lane pipeline event collector with age-based squash filtering,       |
// | in-order DEPTH-entry FIFO and valid/ready drain port.                      |
// | Optional macro ORACLE_QUEUE_DPI_EN forwards drained events to DPI hooks.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module oracle_event_queue #(
    parameter int NB_LANES = 2,
    parameter int DEPTH    = 16,
    parameter int ID_W     = 8,
    parameter int XLEN     = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NB_LANES-1:0]        evt_valid_i,
    input  logic [2*NB_LANES-1:0]      evt_kind_i,
    input  logic [ID_W*NB_LANES-1:0]   evt_id_i,
    input  logic [XLEN*NB_LANES-1:0]   evt_pc_i,
    input  logic [XLEN*NB_LANES-1:0]   evt_data_i,
    input  logic [ID_W-1:0]            head_id_i,
    input  logic                       squash_valid_i,
    input  logic [ID_W-1:0]            squash_id_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [1:0]                 out_kind_o,
    output logic [ID_W-1:0]            out_id_o,
    output logic [XLEN-1:0]            out_pc_o,
    output logic [XLEN-1:0]            out_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic [31:0]                dropped_cnt_o
);

    localparam int                 c_PTR_W       = $clog2(DEPTH);
    localparam int                 c_CNT_W       = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH       = c_CNT_W'(DEPTH);
    localparam logic [1:0]         c_KIND_COMMIT = 2'd3;

    logic [1:0]         r_kind [DEPTH];
    logic [ID_W-1:0]    r_id   [DEPTH];
    logic [XLEN-1:0]    r_pc   [DEPTH];
    logic [XLEN-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0]   r_kill;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic [31:0]        r_dropped;

    logic [1:0]         w_lane_kind [NB_LANES];
    logic [ID_W-1:0]    w_lane_id   [NB_LANES];
    logic [XLEN-1:0]    w_lane_pc   [NB_LANES];
    logic [XLEN-1:0]    w_lane_data [NB_LANES];
    logic [c_CNT_W-1:0] w_rank      [NB_LANES];
    logic [c_PTR_W-1:0] w_slot      [NB_LANES];
    logic [NB_LANES-1:0] w_want;
    logic [NB_LANES-1:0] w_wr_en;
    logic [DEPTH-1:0]   w_ent_kill;
    logic [ID_W-1:0]    w_sq_age;
    logic [c_CNT_W-1:0] w_free;
    logic [c_CNT_W-1:0] w_acc;
    logic [c_CNT_W-1:0] w_total;
    logic [c_CNT_W-1:0] w_pushed;
    logic [c_CNT_W-1:0] w_dropped;
    logic [32:0]        w_drop_sum;
    logic               w_empty;
    logic               w_pop;

    // Ages are measured from the oldest in-flight id so that wrapped ids compare correctly.
    assign w_sq_age = squash_id_i - head_id_i;
    assign w_free   = c_DEPTH - r_count;

    generate
        for (genvar l = 0; l < NB_LANES; l++) begin : g_lane
            logic [ID_W-1:0] w_age;
            assign w_lane_kind[l] = evt_kind_i[2*l +: 2];
            assign w_lane_id[l]   = evt_id_i[ID_W*l +: ID_W];
            assign w_lane_pc[l]   = evt_pc_i[XLEN*l +: XLEN];
            assign w_lane_data[l] = evt_data_i[XLEN*l +: XLEN];
            assign w_age          = w_lane_id[l] - head_id_i;
            assign w_want[l]      = evt_valid_i[l] &&
                                    !(squash_valid_i && (w_lane_kind[l] != c_KIND_COMMIT) &&
                                      (w_age >= w_sq_age));
            assign w_slot[l]      = r_wr_ptr + w_rank[l][c_PTR_W-1:0];
            assign w_wr_en[l]     = w_want[l] && (w_rank[l] < w_free);
        end

        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            localparam logic [c_PTR_W-1:0] c_IDX = c_PTR_W'(i);
            logic [c_PTR_W-1:0] w_offset;
            logic [ID_W-1:0]    w_age;
            assign w_offset      = c_IDX - r_rd_ptr;
            assign w_age         = r_id[i] - head_id_i;
            assign w_ent_kill[i] = ({1'b0, w_offset} < r_count) && squash_valid_i &&
                                   (r_kind[i] != c_KIND_COMMIT) && (w_age >= w_sq_age);
        end
    endgenerate

    // Surviving lanes are compacted: each takes the slot after the previous surviving lane.
    always_comb begin
        w_acc = '0;
        for (int l = 0; l < NB_LANES; l++) begin
            w_rank[l] = w_acc;
            w_acc     = w_acc + {{(c_CNT_W-1){1'b0}}, w_want[l]};
        end
        w_total    = w_acc;
        w_pushed   = (w_total < w_free) ? w_total : w_free;
        w_dropped  = w_total - w_pushed;
        w_drop_sum = {1'b0, r_dropped} + 33'(w_dropped);
    end

    assign w_empty = (r_count == '0);
    // A killed head leaves on its own, regardless of the consumer.
    assign w_pop   = !w_empty && (r_kill[r_rd_ptr] || out_ready_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_kill     <= '0;
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + {{(c_PTR_W-1){1'b0}}, w_pop};
            r_wr_ptr <= r_wr_ptr + w_pushed[c_PTR_W-1:0];
            r_count  <= r_count + w_pushed - {{(c_CNT_W-1){1'b0}}, w_pop};
            for (int i = 0; i < DEPTH; i++) begin
                if (w_ent_kill[i]) begin
                    r_kill[i] <= 1'b1;
                end
            end
            for (int l = 0; l < NB_LANES; l++) begin
                if (w_wr_en[l]) begin
                    r_kill[w_slot[l]] <= 1'b0;
                end
            end
            if (w_dropped != '0) begin
                r_overflow <= 1'b1;
            end
            r_dropped <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int l = 0; l < NB_LANES; l++) begin
                if (w_wr_en[l]) begin
                    r_kind[w_slot[l]] <= w_lane_kind[l];
                    r_id[w_slot[l]]   <= w_lane_id[l];
                    r_pc[w_slot[l]]   <= w_lane_pc[l];
                    r_data[w_slot[l]] <= w_lane_data[l];
                end
            end
        end
    end

    assign out_valid_o   = !w_empty && !r_kill[r_rd_ptr];
    assign out_kind_o    = r_kind[r_rd_ptr];
    assign out_id_o      = r_id[r_rd_ptr];
    assign out_pc_o      = r_pc[r_rd_ptr];
    assign out_data_o    = r_data[r_rd_ptr];
    assign count_o       = r_count;
    assign overflow_o    = r_overflow;
    assign dropped_cnt_o = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_oracle_event_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_oracle_event_queue                                                      |
// | Directed self-checking bench for oracle_event_queue (default parameters).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_oracle_event_queue;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]   evt_valid_i;
    logic [3:0]   evt_kind_i;
    logic [15:0]  evt_id_i;
    logic [127:0] evt_pc_i;
    logic [127:0] evt_data_i;
    logic [7:0]   head_id_i;
    logic         squash_valid_i;
    logic [7:0]   squash_id_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [1:0]   out_kind_o;
    logic [7:0]   out_id_o;
    logic [63:0]  out_pc_o;
    logic [63:0]  out_data_o;
    logic [4:0]   count_o;
    logic         overflow_o;
    logic [31:0]  dropped_cnt_o;

    int n_total = 0;
    int n_bad   = 0;

    oracle_event_queue #(
        .NB_LANES (2),
        .DEPTH    (16),
        .ID_W     (8),
        .XLEN     (64)
    ) u_dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .evt_valid_i    (evt_valid_i),
        .evt_kind_i     (evt_kind_i),
        .evt_id_i       (evt_id_i),
        .evt_pc_i       (evt_pc_i),
        .evt_data_i     (evt_data_i),
        .head_id_i      (head_id_i),
        .squash_valid_i (squash_valid_i),
        .squash_id_i    (squash_id_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_kind_o     (out_kind_o),
        .out_id_o       (out_id_o),
        .out_pc_o       (out_pc_o),
        .out_data_o     (out_data_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .dropped_cnt_o  (dropped_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_lanes();
        evt_valid_i = '0;
        evt_kind_i  = '0;
        evt_id_i    = '0;
        evt_pc_i    = '0;
        evt_data_i  = '0;
    endtask

    task automatic set_lane(input int l, input logic [1:0] k, input logic [7:0] id,
                            input logic [63:0] pc, input logic [63:0] d);
        evt_valid_i[l]          = 1'b1;
        evt_kind_i[2*l +: 2]    = k;
        evt_id_i[8*l +: 8]      = id;
        evt_pc_i[64*l +: 64]    = pc;
        evt_data_i[64*l +: 64]  = d;
    endtask

    initial begin
        rst_ni         = 1'b0;
        out_ready_i    = 1'b1;
        head_id_i      = '0;
        squash_valid_i = 1'b0;
        squash_id_i    = '0;
        clear_lanes();

        // Reset state
        step();
        step();
        rst_ni = 1'b1;
        check_value("rst_count", 64'(count_o), 64'd0);
        check_value("rst_valid", 64'(out_valid_o), 64'd0);
        check_value("rst_ovf", 64'(overflow_o), 64'd0);
        check_value("rst_drop", 64'(dropped_cnt_o), 64'd0);

        // Single commit, visible one cycle after capture
        set_lane(0, 2'd3, 8'd5, 64'h8000_0000, 64'h0);
        step();
        clear_lanes();
        check_value("t1_valid", 64'(out_valid_o), 64'd1);
        check_value("t1_id", 64'(out_id_o), 64'd5);
        check_value("t1_kind", 64'(out_kind_o), 64'd3);
        check_value("t1_pc", out_pc_o, 64'h8000_0000);
        check_value("t1_count", 64'(count_o), 64'd1);
        step();
        check_value("t1_count_after", 64'(count_o), 64'd0);
        check_value("t1_valid_after", 64'(out_valid_o), 64'd0);

        // Overflow with both lanes every cycle, no consumer
        out_ready_i = 1'b0;
        set_lane(0, 2'd0, 8'd1, 64'h100, 64'h11);
        set_lane(1, 2'd0, 8'd2, 64'h104, 64'h22);
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 7) check_value("t2_count_full", 64'(count_o), 64'd16);
        end
        check_value("t2_count", 64'(count_o), 64'd16);
        check_value("t2_ovf", 64'(overflow_o), 64'd1);
        check_value("t2_drop", 64'(dropped_cnt_o), 64'd4);
        check_value("t2_head", 64'(out_id_o), 64'd1);
        // Full with a pop: pushes still dropped, pop completes
        out_ready_i = 1'b1;
        step();
        clear_lanes();
        check_value("t2_drop_full_pop", 64'(dropped_cnt_o), 64'd6);
        check_value("t2_count_full_pop", 64'(count_o), 64'd15);
        for (int k = 0; k < 15; k++) begin
            check_value("t2_drain_valid", 64'(out_valid_o), 64'd1);
            check_value("t2_drain_id", 64'(out_id_o), (k % 2 == 0) ? 64'd2 : 64'd1);
            step();
        end
        check_value("t2_count_end", 64'(count_o), 64'd0);

        // Squash on stored entries
        out_ready_i = 1'b0;
        head_id_i   = 8'd2;
        set_lane(0, 2'd2, 8'd3, 64'h200, 64'h3);
        set_lane(1, 2'd2, 8'd4, 64'h204, 64'h4);
        step();
        clear_lanes();
        set_lane(0, 2'd2, 8'd5, 64'h208, 64'h5);
        set_lane(1, 2'd2, 8'd6, 64'h20c, 64'h6);
        step();
        clear_lanes();
        set_lane(0, 2'd3, 8'd4, 64'h204, 64'h0);
        step();
        clear_lanes();
        squash_valid_i = 1'b1;
        squash_id_i    = 8'd5;
        step();
        squash_valid_i = 1'b0;
        check_value("t3_count", 64'(count_o), 64'd5);
        out_ready_i = 1'b1;
        check_value("t3_v0", 64'(out_valid_o), 64'd1);
        check_value("t3_id0", 64'(out_id_o), 64'd3);
        check_value("t3_k0", 64'(out_kind_o), 64'd2);
        step();
        check_value("t3_v1", 64'(out_valid_o), 64'd1);
        check_value("t3_id1", 64'(out_id_o), 64'd4);
        check_value("t3_k1", 64'(out_kind_o), 64'd2);
        step();
        check_value("t3_kill5", 64'(out_valid_o), 64'd0);
        step();
        check_value("t3_kill6", 64'(out_valid_o), 64'd0);
        step();
        check_value("t3_v2", 64'(out_valid_o), 64'd1);
        check_value("t3_id2", 64'(out_id_o), 64'd4);
        check_value("t3_k2", 64'(out_kind_o), 64'd3);
        step();
        check_value("t3_count_end", 64'(count_o), 64'd0);

        // Id wrap-around in the age comparison
        out_ready_i = 1'b0;
        head_id_i   = 8'd250;
        set_lane(0, 2'd1, 8'd252, 64'h300, 64'h1);
        set_lane(1, 2'd1, 8'd254, 64'h304, 64'h2);
        step();
        clear_lanes();
        set_lane(0, 2'd1, 8'd1, 64'h308, 64'h3);
        step();
        clear_lanes();
        squash_valid_i = 1'b1;
        squash_id_i    = 8'd254;
        step();
        squash_valid_i = 1'b0;
        out_ready_i    = 1'b1;
        check_value("t4_v0", 64'(out_valid_o), 64'd1);
        check_value("t4_id0", 64'(out_id_o), 64'd252);
        step();
        check_value("t4_kill254", 64'(out_valid_o), 64'd0);
        step();
        check_value("t4_kill1", 64'(out_valid_o), 64'd0);
        step();
        check_value("t4_count_end", 64'(count_o), 64'd0);

        // Same-cycle squash of incoming lanes: commit survives
        out_ready_i    = 1'b0;
        head_id_i      = 8'd0;
        set_lane(0, 2'd1, 8'd7, 64'h400, 64'h7);
        set_lane(1, 2'd3, 8'd7, 64'h400, 64'h0);
        squash_valid_i = 1'b1;
        squash_id_i    = 8'd7;
        step();
        clear_lanes();
        squash_valid_i = 1'b0;
        check_value("t5_count", 64'(count_o), 64'd1);
        check_value("t5_kind", 64'(out_kind_o), 64'd3);
        check_value("t5_id", 64'(out_id_o), 64'd7);
        check_value("t5_drop", 64'(dropped_cnt_o), 64'd6);
        out_ready_i = 1'b1;
        step();
        check_value("t5_count_end", 64'(count_o), 64'd0);

        // Reset dominates a simultaneous push
        out_ready_i = 1'b0;
        set_lane(0, 2'd2, 8'd10, 64'h500, 64'h0);
        set_lane(1, 2'd2, 8'd11, 64'h504, 64'h0);
        for (int i = 0; i < 4; i++) step();
        evt_valid_i[1] = 1'b0;
        step();
        check_value("t6_count9", 64'(count_o), 64'd9);
        evt_valid_i[1] = 1'b1;
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        clear_lanes();
        check_value("t6_count", 64'(count_o), 64'd0);
        check_value("t6_valid", 64'(out_valid_o), 64'd0);
        check_value("t6_ovf", 64'(overflow_o), 64'd0);
        check_value("t6_drop", 64'(dropped_cnt_o), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
